// File: rtl/dp_ram_batch_controller.sv
// dp_ram_batch_controller
//   Walks a batch of operand words held in a dual-port RAM shared with the HPS.
//   For each channel it reads DATA_IN[i], hands A/B to the multiplier, pulses
//   start, waits for done and writes the product back to DATA_OUT[i]. When the
//   batch is complete it posts STATUS and then performs the go/clear handshake
//   with software.
//
//   Optional feature: define DP_RAM_BATCH_TIMEOUT_EN to bound the wait for done
//   to TIMEOUT cycles. On expiry the channel gets 32'hFFFF_FFFF, err is set and
//   the rest of the batch is skipped.
//
// Ports
//   CLK, rst        clock (rising edge), asynchronous active-low reset
//   ADDR            RAM word address
//   WRITE_F         RAM write strobe, one cycle per write
//   WRITE_DATA      RAM write data
//   READ_DATA       RAM read data, registered (valid one cycle after ADDR)
//   BYTE_ENABLE     always 4'b1111
//   A, B            multiplier operands, stable from S_START to S_WR_OUT
//   start           one-cycle multiplier start pulse
//   done, Y         multiplier result valid / product
//   busy            high whenever the FSM is not in S_IDLE
//   state_o         current state encoding
//
// state      | meaning
// S_IDLE     | ADDR=0, wait for CONTROL.go, latch batch size
// S_RD_ADDR  | present DATA_IN[i] address
// S_RD_WAIT  | RAM read latency
// S_START    | A/B valid, start pulse
// S_WAIT_DONE| wait for multiplier done (optionally bounded)
// S_WR_OUT   | write product to DATA_OUT[i]
// S_NEXT     | advance channel or finish
// S_SET_STAT | write STATUS {cnt, err, fin}
// S_WAIT_CLR | wait for software to drop go
// S_CLEAR    | clear STATUS

module dp_ram_batch_controller #(
    parameter int OP_W    = 4,
    parameter int N_CH    = 4,
    parameter int AW      = 4,
    parameter int TIMEOUT = 4095
) (
    input  logic                CLK,
    input  logic                rst,
    output logic [AW-1:0]       ADDR,
    output logic                WRITE_F,
    output logic [31:0]         WRITE_DATA,
    input  logic [31:0]         READ_DATA,
    output logic [3:0]          BYTE_ENABLE,
    output logic [OP_W-1:0]     A,
    output logic [OP_W-1:0]     B,
    output logic                start,
    input  logic                done,
    input  logic [2*OP_W-1:0]   Y,
    output logic                busy,
    output logic [3:0]          state_o
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_RD_ADDR   = 4'd1,
        S_RD_WAIT   = 4'd2,
        S_START     = 4'd3,
        S_WAIT_DONE = 4'd4,
        S_WR_OUT    = 4'd5,
        S_NEXT      = 4'd6,
        S_SET_STAT  = 4'd7,
        S_WAIT_CLR  = 4'd8,
        S_CLEAR     = 4'd9
    } state_t;

    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

    state_t            state, state_n;
    logic [IW-1:0]     i, i_n, i_last, i_last_n;
    logic [7:0]        cnt, cnt_n;
    logic              err, err_n;
    logic              rd0_valid;
    logic              tmo_hit;
    logic [7:0]        n_rd;
    logic [AW-1:0]     addr_n;
    logic              wf_n, start_n;
    logic [31:0]       wd_n;
    logic [OP_W-1:0]   a_n, b_n;
    logic              unused_rd;

    assign BYTE_ENABLE = 4'b1111;
    assign state_o     = state;
    assign n_rd        = READ_DATA[15:8];
    assign unused_rd   = ^READ_DATA;

    function automatic logic [AW-1:0] in_addr(input logic [IW-1:0] idx);
        return AW'(32'(idx) + 32'd2);
    endfunction

    function automatic logic [AW-1:0] out_addr(input logic [IW-1:0] idx);
        return AW'(32'(idx) + 32'(N_CH) + 32'd2);
    endfunction

`ifdef DP_RAM_BATCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmr;

    // Down-counter loaded as S_WAIT_DONE is entered; expiry on its last cycle.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst)                                     tmr <= '0;
        else if (state == S_START)                    tmr <= TW'(TIMEOUT);
        else if (state == S_WAIT_DONE && tmr != '0)   tmr <= tmr - 1'b1;
    end

    assign tmo_hit = (state == S_WAIT_DONE) && !done && (tmr <= TW'(1));
`else
    logic unused_tmo;
    assign tmo_hit    = 1'b0;
    assign unused_tmo = (TIMEOUT != 0);
`endif

    // READ_DATA reflects last cycle's ADDR; CONTROL is only trusted once ADDR
    // has been 0 for a full cycle, so a stale STATUS read cannot look like go.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) rd0_valid <= 1'b0;
        else      rd0_valid <= (ADDR == '0);
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            i          <= '0;
            i_last     <= '0;
            cnt        <= '0;
            err        <= 1'b0;
            ADDR       <= '0;
            WRITE_F    <= 1'b0;
            WRITE_DATA <= '0;
            A          <= '0;
            B          <= '0;
            start      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            i          <= i_n;
            i_last     <= i_last_n;
            cnt        <= cnt_n;
            err        <= err_n;
            ADDR       <= addr_n;
            WRITE_F    <= wf_n;
            WRITE_DATA <= wd_n;
            A          <= a_n;
            B          <= b_n;
            start      <= start_n;
            busy       <= (state_n != S_IDLE);
        end
    end

    // Outputs are computed for the state being entered so they are registered.
    always_comb begin
        state_n  = state;
        i_n      = i;
        i_last_n = i_last;
        cnt_n    = cnt;
        err_n    = err;
        addr_n   = '0;
        wf_n     = 1'b0;
        wd_n     = '0;
        a_n      = A;
        b_n      = B;
        start_n  = 1'b0;
        case (state)
            S_IDLE: begin
                if (rd0_valid && READ_DATA[0]) begin
                    state_n = S_RD_ADDR;
                    i_n     = '0;
                    cnt_n   = '0;
                    err_n   = 1'b0;
                    if (n_rd == 8'd0 || n_rd > 8'(N_CH)) i_last_n = IW'(N_CH - 1);
                    else                                 i_last_n = IW'(32'(n_rd) - 32'd1);
                    addr_n  = in_addr('0);
                end
            end
            S_RD_ADDR: begin
                state_n = S_RD_WAIT;
                addr_n  = in_addr(i);
            end
            S_RD_WAIT: begin
                state_n = S_START;
                addr_n  = in_addr(i);
                a_n     = READ_DATA[OP_W-1:0];
                b_n     = READ_DATA[2*OP_W-1:OP_W];
                start_n = 1'b1;
            end
            S_START: begin
                state_n = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (done) begin
                    state_n = S_WR_OUT;
                    addr_n  = out_addr(i);
                    wf_n    = 1'b1;
                    wd_n    = 32'(Y);
                    cnt_n   = cnt + 8'd1;
                end else if (tmo_hit) begin
                    state_n = S_WR_OUT;
                    addr_n  = out_addr(i);
                    wf_n    = 1'b1;
                    wd_n    = 32'hFFFF_FFFF;
                    err_n   = 1'b1;
                end
            end
            S_WR_OUT: begin
                state_n = S_NEXT;
            end
            S_NEXT: begin
                if (i == i_last || err) begin
                    state_n = S_SET_STAT;
                    addr_n  = AW'(1);
                    wf_n    = 1'b1;
                    wd_n    = {16'h0, cnt, 6'b0, err, 1'b1};
                end else begin
                    state_n = S_RD_ADDR;
                    i_n     = i + 1'b1;
                    addr_n  = in_addr(i + 1'b1);
                end
            end
            S_SET_STAT: begin
                state_n = S_WAIT_CLR;
            end
            S_WAIT_CLR: begin
                if (rd0_valid && !READ_DATA[0]) begin
                    state_n = S_CLEAR;
                    addr_n  = AW'(1);
                    wf_n    = 1'b1;
                end
            end
            S_CLEAR: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dp_ram_batch_controller.sv
// Bench for dp_ram_batch_controller: RAM with registered read, a multiplier
// with random latency (done stays high until the next start), and a reference
// model of the expected RAM write sequence per batch.
module tb_dp_ram_batch_controller;

    localparam int OP_W    = 4;
    localparam int N_CH    = 4;
    localparam int AW      = 4;
    localparam int TIMEOUT = 16;

    logic               CLK = 1'b0;
    logic               rst = 1'b0;
    logic [AW-1:0]      ADDR;
    logic               WRITE_F;
    logic [31:0]        WRITE_DATA;
    logic [31:0]        READ_DATA = '0;
    logic [3:0]         BYTE_ENABLE;
    logic [OP_W-1:0]    A, B;
    logic               start;
    logic               done = 1'b1;
    logic [2*OP_W-1:0]  Y = 8'hEE;
    logic               busy;
    logic [3:0]         state_o;

    always #5 CLK = ~CLK;

    dp_ram_batch_controller #(.OP_W(OP_W), .N_CH(N_CH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .rst(rst), .ADDR(ADDR), .WRITE_F(WRITE_F), .WRITE_DATA(WRITE_DATA),
        .READ_DATA(READ_DATA), .BYTE_ENABLE(BYTE_ENABLE), .A(A), .B(B), .start(start),
        .done(done), .Y(Y), .busy(busy), .state_o(state_o)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [31:0]   mem [0:15];
    logic          sw_we = 1'b0;
    logic [AW-1:0] sw_addr = '0;
    logic [31:0]   sw_data = '0;
    logic [31:0]   din [N_CH];
    wr_t           wq[$];
    logic [7:0]    sq[$];
    int            bad_addr = 0;
    int            wd_run = 0;
    int            hang_idx = -1;
    int            lat_cnt = 0;
    logic [7:0]    y_hold = '0;

    // Dual-port RAM: DUT port and software port, registered read on DUT port.
    always @(posedge CLK) begin
        if (WRITE_F) mem[ADDR] <= WRITE_DATA;
        if (sw_we)   mem[sw_addr] <= sw_data;
        READ_DATA <= mem[ADDR];
    end

    // Multiplier: done drops on start, rises after 1..5 cycles and stays high.
    always @(posedge CLK) begin
        if (start) begin
            done    <= 1'b0;
            y_hold  <= {4'b0, A} * {4'b0, B};
            lat_cnt <= (sq.size() - 1 == hang_idx) ? 0 : int'($urandom_range(1, 5));
        end else if (lat_cnt > 0) begin
            lat_cnt <= lat_cnt - 1;
            if (lat_cnt == 1) begin
                done <= 1'b1;
                Y    <= y_hold;
            end
        end
    end

    always @(negedge CLK) begin
        if (WRITE_F) begin
            wq.push_back({ADDR, WRITE_DATA});
            if (32'(ADDR) == 0 || 32'(ADDR) >= 2 + 2 * N_CH) bad_addr++;
        end
        if (start) begin
            sq.push_back({B, A});
            wd_run = 0;
        end
        if (state_o == 4'd4) wd_run++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic wr_t wr_at(input int k);
        return (k < wq.size()) ? wq[k] : '1;
    endfunction

    function automatic logic [7:0] st_at(input int k);
        return (k < sq.size()) ? sq[k] : 8'hXX;
    endfunction

    task automatic sw_write(input logic [AW-1:0] a, input logic [31:0] d);
        @(negedge CLK);
        sw_we = 1'b1; sw_addr = a; sw_data = d;
        @(negedge CLK);
        sw_we = 1'b0;
    endtask

    task automatic wait_busy(input logic want, input int budget, input string tag);
        int k = 0;
        while (busy !== want && k < budget) begin @(negedge CLK); k++; end
        check(tag, 32'(busy), 32'(want));
    endtask

    task automatic wait_writes(input int cnt, input int budget, input string tag);
        int k = 0;
        while (wq.size() < cnt && k < budget) begin @(negedge CLK); k++; end
        check(tag, 32'(wq.size() >= cnt), 32'd1);
    endtask

    task automatic load_batch(input logic [7:0] n);
        wq.delete();
        sq.delete();
        for (int k = 0; k < N_CH; k++) sw_write(AW'(2 + k), din[k]);
        sw_write('0, {16'h0, n, 8'h01});
    endtask

    // Reference: channels k < n_eff produce DATA_OUT[k] = A*B in order, then
    // STATUS = {n_eff, fin}; after go drops, STATUS is cleared.
    task automatic run_batch(input logic [7:0] n, input bit clr_early, input string tag);
        int          ne;
        wr_t         w;
        logic [31:0] prod;
        logic [31:0] stat;
        ne   = (n == 8'd0 || 32'(n) > N_CH) ? N_CH : 32'(n);
        stat = {16'h0, 8'(ne), 8'h01};
        load_batch(n);
        wait_busy(1'b1, 20, {tag, "_busy"});
        if (clr_early) sw_write('0, 32'h0);
        wait_writes(ne + 1, 2000, {tag, "_writes"});
        for (int k = 0; k < ne; k++) begin
            prod = 32'(din[k][3:0]) * 32'(din[k][7:4]);
            w = wr_at(k);
            check($sformatf("%s_ab%0d", tag, k), 32'(st_at(k)), 32'(din[k][7:0]));
            check($sformatf("%s_oaddr%0d", tag, k), 32'(w.a), 32'(2 + N_CH + k));
            check($sformatf("%s_odata%0d", tag, k), w.d, prod);
            check($sformatf("%s_mem%0d", tag, k), mem[2 + N_CH + k], prod);
        end
        w = wr_at(ne);
        check({tag, "_saddr"}, 32'(w.a), 32'd1);
        check({tag, "_sdata"}, w.d, stat);
        if (!clr_early) begin
            repeat (6) @(negedge CLK);
            check({tag, "_hold_state"}, 32'(state_o), 32'd8);
            check({tag, "_hold_nwr"}, 32'(wq.size()), 32'(ne + 1));
            check({tag, "_hold_stat"}, mem[1], stat);
            sw_write('0, 32'h0);
        end
        wait_writes(ne + 2, 100, {tag, "_clrwr"});
        wait_busy(1'b0, 20, {tag, "_idle"});
        w = wr_at(ne + 1);
        check({tag, "_caddr"}, 32'(w.a), 32'd1);
        check({tag, "_cdata"}, w.d, 32'd0);
        check({tag, "_cmem"}, mem[1], 32'd0);
        check({tag, "_nstart"}, 32'(sq.size()), 32'(ne));
    endtask

    initial begin
        logic [7:0] nr;
        int         k;
        wr_t        w;
        for (int a = 0; a < 16; a++) sw_write(AW'(a), 32'h0);
        @(negedge CLK);
        check("rst_addr",  32'(ADDR), 32'd0);
        check("rst_wf",    32'(WRITE_F), 32'd0);
        check("rst_wd",    WRITE_DATA, 32'd0);
        check("rst_a",     32'(A), 32'd0);
        check("rst_b",     32'(B), 32'd0);
        check("rst_start", 32'(start), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_state", 32'(state_o), 32'd0);
        check("byte_en",   32'(BYTE_ENABLE), 32'hF);
        rst = 1'b1;
        repeat (3) @(negedge CLK);

        // Single channel; done is stale-high from before go.
        din[0] = 32'h0000_0053;
        for (int c = 1; c < N_CH; c++) din[c] = $urandom;
        run_batch(8'd1, 1'b0, "t1");

        // n = 0 selects all channels.
        for (int c = 0; c < N_CH; c++) din[c] = 32'h0000_00FF;
        run_batch(8'd0, 1'b0, "t2");

        // n larger than N_CH saturates.
        for (int c = 0; c < N_CH; c++) din[c] = $urandom;
        run_batch(8'd9, 1'b0, "t3");

        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < N_CH; c++) din[c] = $urandom;
            nr = 8'($urandom_range(0, 12));
            run_batch(nr, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
        end

        // Reset in S_WAIT_DONE of channel 2 abandons the batch.
        hang_idx = 2;
        for (int c = 0; c < N_CH; c++) din[c] = $urandom;
        load_batch(8'd4);
        k = 0;
        while (!(sq.size() == 3 && state_o == 4'd4) && k < 500) begin @(negedge CLK); k++; end
        check("t5_reach", 32'(sq.size() == 3 && state_o == 4'd4), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("t5_addr",  32'(ADDR), 32'd0);
        check("t5_wf",    32'(WRITE_F), 32'd0);
        check("t5_wd",    WRITE_DATA, 32'd0);
        check("t5_ab",    32'({A, B}), 32'd0);
        check("t5_start", 32'(start), 32'd0);
        check("t5_busy",  32'(busy), 32'd0);
        check("t5_state", 32'(state_o), 32'd0);
        check("t5_stat",  mem[1], 32'd0);
        check("t5_nwr",   32'(wq.size()), 32'd2);
        hang_idx = -1;
        sw_write('0, 32'h0);
        @(negedge CLK);
        rst = 1'b1;
        repeat (6) @(negedge CLK);
        check("t5_idle",  32'(state_o), 32'd0);
        check("t5_stat2", mem[1], 32'd0);
        check("t5_nwr2",  32'(wq.size()), 32'd2);

`ifdef DP_RAM_BATCH_TIMEOUT_EN
        // Channel 1 never completes: timeout marker, err, skip the rest.
        hang_idx = 1;
        for (int c = 0; c < N_CH; c++) din[c] = $urandom;
        load_batch(8'd4);
        wait_writes(3, 500, "t6_writes");
        w = wr_at(0);
        check("t6_d0", w.d, 32'(din[0][3:0]) * 32'(din[0][7:4]));
        w = wr_at(1);
        check("t6_a1", 32'(w.a), 32'(2 + N_CH + 1));
        check("t6_d1", w.d, 32'hFFFF_FFFF);
        w = wr_at(2);
        check("t6_sa", 32'(w.a), 32'd1);
        check("t6_sd", w.d, 32'h0000_0103);
        check("t6_cycles", 32'(wd_run), 32'(TIMEOUT));
        check("t6_nstart", 32'(sq.size()), 32'd2);
        hang_idx = -1;
        sw_write('0, 32'h0);
        wait_writes(4, 100, "t6_clrwr");
        wait_busy(1'b0, 20, "t6_idle");
        check("t6_cmem", mem[1], 32'd0);
`endif

        check("addr_range", 32'(bad_addr), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
